ysyx_24090003_lsu: RTL and testbench
====================================

YSYX_24090003_LSU -- requirements
Module: ysyx_24090003_lsu

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the bus-wait cycle limit before a request is aborted with error.
REQ-002 cpu_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 cpu_rs  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 req_valid  in  1  SHALL mean the core presents a load/store request.
REQ-005 req_ready  out  1  SHALL mean the LSU accepts a request this cycle.
REQ-006 req_wen  in  1  SHALL select store (1) or load (0).
REQ-007 req_funct  in  3  SHALL carry RV32I funct3 (load 0/1/2/4/5, store 0/1/2).
REQ-008 req_addr  in  32  SHALL carry the byte address; req_wdata  in  32  SHALL carry the store data (low-aligned).
REQ-009 resp_valid  out  1, resp_ready  in  1  SHALL form the response handshake.
REQ-010 resp_rdata  out  32  SHALL carry the formatted load result; resp_err  out  1  SHALL flag a failed access.
REQ-011 mem_valid  out  1, mem_ready  in  1  SHALL form the bus request handshake.
REQ-012 mem_wen  out  1, mem_addr  out  32 (bits [1:0] always 0), mem_wdata  out  32, mem_wstrb  out  4  SHALL describe the bus request.
REQ-013 mem_rvalid  in  1, mem_rdata  in  32, mem_rerr  in  1  SHALL carry the bus read return.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, WAIT, DONE; req_ready = 1 only in IDLE.
REQ-015 IDLE: on req_valid the LSU SHALL register wen/funct/addr/wdata, clear the timeout counter, and go to REQ next cycle (or DONE with resp_err=1 for an illegal funct3, no bus access).
REQ-016 REQ: mem_valid SHALL be 1 with stable fields until mem_ready=1; store then goes to DONE, load goes to WAIT.
REQ-017 WAIT: on mem_rvalid the LSU SHALL capture formatted data and mem_rerr into resp_err and go to DONE.
REQ-018 DONE: resp_valid SHALL be 1 with stable data until resp_ready=1, then return to IDLE; minimum request-to-response latency is 2 cycles (store) and 3 cycles (load).
REQ-019 Store strobes: SB wstrb = 1<<addr[1:0], byte replicated on all 4 lanes; SH wstrb = 4'b0011<<(2*addr[1]), halfword replicated on both halves; SW wstrb = 4'hF.
REQ-020 Loads SHALL select lane by addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-021 The timeout counter SHALL increment each cycle in REQ/WAIT; on reaching TIMEOUT the LSU SHALL drop mem_valid, go to DONE with resp_err=1, resp_rdata=0; a mem_rvalid arriving later SHALL be ignored.
REQ-022 resp_rdata SHALL be 0 for every store and every errored access.
REQ-023 mem_rvalid outside WAIT and mem_ready outside REQ SHALL be ignored.

Reset
REQ-024 Asserting cpu_rs low SHALL immediately force IDLE, counter 0, mem_valid=0, resp_valid=0, resp_err=0, resp_rdata=0, all mem_* outputs 0; req_ready=1.
REQ-025 Reset mid-transaction SHALL abandon it with no response and no further bus activity.

Configuration
REQ-026 With YSYX_24090003_LSU_MISALIGN_CHK_EN defined, LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL go IDLE->DONE with resp_err=1 and no bus request.
REQ-027 Without YSYX_24090003_LSU_MISALIGN_CHK_EN, those accesses SHALL proceed using the lane rules of REQ-019/020 (addr[0] ignored for half, addr[1:0] ignored for word), resp_err=0.

Verification
REQ-028 LB addr 0x8000_0003, mem_rdata 0x8012_3456 -> mem_addr 0x8000_0000, resp_rdata 0xFFFF_FF80, resp_err 0.
REQ-029 SH addr 0x8000_0002 wdata 0x0000_BEEF -> mem_wstrb 4'b1100, mem_wdata 0xBEEF_BEEF, resp_valid 2 cycles after accept with mem_ready=1.
REQ-030 LW with mem_ready held 0 for TIMEOUT cycles -> mem_valid drops, resp_err 1, resp_rdata 0.
REQ-031 LHU addr 0x8000_0001 -> with macro: resp_err 1, mem_valid never 1; without macro: lanes [15:0] returned zero-extended.
REQ-032 resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready 0 throughout.
REQ-033 cpu_rs low while in WAIT -> outputs at reset values immediately, no resp_valid after release.

Source files
------------

// File: rtl/ysyx_24090003_lsu.sv
// rtl/ysyx_24090003_lsu.sv - RV32I load/store unit with bus timeout
// Optional: define YSYX_24090003_LSU_MISALIGN_CHK_EN to reject misaligned half/word accesses.
module ysyx_24090003_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        cpu_clk,
  input  logic        cpu_rs,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rerr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic          wen_q;
  logic [2:0]    funct_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          bad_funct;
  logic          misalign;
  logic          reject;
  logic          timed_out;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_data;
  logic [31:0]   st_data;
  logic [3:0]    st_strb;

  always_comb begin
    bad_funct = 1'b0;
    misalign  = 1'b0;
    if (req_wen) begin
      bad_funct = (req_funct > 3'd2);
    end else begin
      case (req_funct)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: bad_funct = 1'b0;
        default:                      bad_funct = 1'b1;
      endcase
    end
`ifdef YSYX_24090003_LSU_MISALIGN_CHK_EN
    case (req_funct[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
    reject = bad_funct | misalign;
  end

  // The handshake has priority over an expiring counter in the same cycle.
  assign timed_out = (cnt_q >= CW'(TIMEOUT - 1));

  always_comb begin
    byte_v = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: byte_v = mem_rdata[7:0];
      2'd1: byte_v = mem_rdata[15:8];
      2'd2: byte_v = mem_rdata[23:16];
      2'd3: byte_v = mem_rdata[31:24];
      default: byte_v = mem_rdata[7:0];
    endcase
    half_v = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct_q)
      3'd0:    load_data = {{24{byte_v[7]}}, byte_v};
      3'd1:    load_data = {{16{half_v[15]}}, half_v};
      3'd4:    load_data = {24'd0, byte_v};
      3'd5:    load_data = {16'd0, half_v};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    case (funct_q[1:0])
      2'b00: begin
        st_data = {4{wdata_q[7:0]}};
        st_strb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_data = {2{wdata_q[15:0]}};
        st_strb = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: begin
        st_data = wdata_q;
        st_strb = 4'hF;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rs) begin
    if (!cpu_rs) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = reject ? DONE : REQ;
      REQ: begin
        if (mem_ready)      state_nxt = wen_q ? DONE : WAIT;
        else if (timed_out) state_nxt = DONE;
      end
      WAIT: if (mem_rvalid || timed_out) state_nxt = DONE;
      DONE: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rs) begin
    if (!cpu_rs) begin
      wen_q   <= 1'b0;
      funct_q <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wen_q   <= req_wen;
          funct_q <= req_funct;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          cnt_q   <= '0;
          rdata_q <= 32'd0;
          err_q   <= reject;
        end
        REQ: begin
          cnt_q <= cnt_q + CW'(1);
          if (!mem_ready && timed_out) err_q <= 1'b1;
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (mem_rvalid) begin
            err_q   <= mem_rerr;
            rdata_q <= mem_rerr ? 32'd0 : load_data;
          end else if (timed_out) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_valid  = (state == REQ);
  assign mem_wen    = mem_valid & wen_q;
  assign mem_addr   = mem_valid ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata  = mem_wen ? st_data : 32'd0;
  assign mem_wstrb  = mem_wen ? st_strb : 4'd0;

endmodule

// File: tb/tb_ysyx_24090003_lsu.sv
// tb/tb_ysyx_24090003_lsu.sv - directed self-checking bench for the load/store unit
module tb_ysyx_24090003_lsu;

  localparam int TO = 8;

  logic        cpu_clk = 1'b0;
  logic        cpu_rs = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [2:0]  req_funct = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_rerr = 1'b0;

  int errors = 0;
  int checks = 0;

  ysyx_24090003_lsu #(.TIMEOUT(TO)) dut (
    .cpu_clk(cpu_clk), .cpu_rs(cpu_rs),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [2:0] funct,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_wen   = wen;
    req_funct = funct;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    cpu_rs = 1'b1;
    tick();

    // LB sign-extended from lane 3
    issue(1'b0, 3'd0, 32'h8000_0003, 32'd0);
    check("lb_mem_valid", 32'(mem_valid), 32'd1);
    check("lb_mem_addr", mem_addr, 32'h8000_0000);
    check("lb_mem_wen", 32'(mem_wen), 32'd0);
    check("lb_req_ready", 32'(req_ready), 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("lb_wait_mem_valid", 32'(mem_valid), 32'd0);
    check("lb_wait_resp_valid", 32'(resp_valid), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8012_3456;
    tick();
    mem_rvalid = 1'b0;
    check("lb_resp_valid", 32'(resp_valid), 32'd1);
    check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    check("lb_err", 32'(resp_err), 32'd0);
    finish_resp();
    check("lb_back_idle", 32'(req_ready), 32'd1);
    check("lb_resp_drop", 32'(resp_valid), 32'd0);

    // SH upper half, 2-cycle store latency
    issue(1'b1, 3'd1, 32'h8000_0002, 32'h0000_BEEF);
    check("sh_mem_valid", 32'(mem_valid), 32'd1);
    check("sh_mem_wen", 32'(mem_wen), 32'd1);
    check("sh_wstrb", 32'(mem_wstrb), 32'hC);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh_addr", mem_addr, 32'h8000_0000);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("sh_resp_valid", 32'(resp_valid), 32'd1);
    check("sh_rdata", resp_rdata, 32'd0);
    check("sh_err", 32'(resp_err), 32'd0);
    finish_resp();

    // SB lane 1 and SW
    issue(1'b1, 3'd0, 32'h8000_0001, 32'h1234_56A5);
    check("sb_wstrb", 32'(mem_wstrb), 32'h2);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("sb_resp_valid", 32'(resp_valid), 32'd1);
    finish_resp();
    issue(1'b1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF);
    check("sw_wstrb", 32'(mem_wstrb), 32'hF);
    check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("sw_addr", mem_addr, 32'h8000_0004);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    finish_resp();

    // LH upper half, response held off for 5 cycles
    issue(1'b0, 3'd1, 32'h8000_0002, 32'd0);
    mem_ready = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_5555;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h8001_1234;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, 32'hFFFF_8001);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    finish_resp();

    // LBU lane 2, then LW with bus error
    issue(1'b0, 3'd4, 32'h8000_0002, 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h11C2_3344;
    tick();
    mem_rvalid = 1'b0;
    check("lbu_rdata", resp_rdata, 32'h0000_00C2);
    finish_resp();
    issue(1'b0, 3'd2, 32'h8000_0008, 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rerr = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    mem_rerr = 1'b0;
    check("rerr_err", 32'(resp_err), 32'd1);
    check("rerr_rdata", resp_rdata, 32'd0);
    finish_resp();

    // Illegal funct3 for load and store
    issue(1'b0, 3'd3, 32'h8000_0000, 32'd0);
    check("ill_ld_mem_valid", 32'(mem_valid), 32'd0);
    check("ill_ld_resp_valid", 32'(resp_valid), 32'd1);
    check("ill_ld_err", 32'(resp_err), 32'd1);
    finish_resp();
    issue(1'b1, 3'd4, 32'h8000_0000, 32'h1);
    check("ill_st_mem_valid", 32'(mem_valid), 32'd0);
    check("ill_st_err", 32'(resp_err), 32'd1);
    finish_resp();

    // LW timeout with mem_ready held low
    issue(1'b0, 3'd2, 32'h8000_0010, 32'd0);
    for (int i = 0; i < TO; i++) begin
      check("to_mem_valid_hi", 32'(mem_valid), 32'd1);
      tick();
    end
    check("to_mem_valid_lo", 32'(mem_valid), 32'd0);
    check("to_resp_valid", 32'(resp_valid), 32'd1);
    check("to_err", 32'(resp_err), 32'd1);
    check("to_rdata", resp_rdata, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234_5678;
    finish_resp();
    tick();
    mem_rvalid = 1'b0;
    check("to_late_resp_valid", 32'(resp_valid), 32'd0);
    check("to_late_req_ready", 32'(req_ready), 32'd1);

    // LHU with addr[0]=1
    issue(1'b0, 3'd5, 32'h8000_0001, 32'd0);
`ifdef YSYX_24090003_LSU_MISALIGN_CHK_EN
    check("lhu_mis_mem_valid", 32'(mem_valid), 32'd0);
    check("lhu_mis_err", 32'(resp_err), 32'd1);
    check("lhu_mis_resp_valid", 32'(resp_valid), 32'd1);
`else
    check("lhu_mem_valid", 32'(mem_valid), 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234_ABCD;
    tick();
    mem_rvalid = 1'b0;
    check("lhu_rdata", resp_rdata, 32'h0000_ABCD);
    check("lhu_err", 32'(resp_err), 32'd0);
`endif
    finish_resp();

    // Reset while waiting for read data
    issue(1'b0, 3'd2, 32'h8000_0020, 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #2 cpu_rs = 1'b0;
    #1;
    check("rstw_req_ready", 32'(req_ready), 32'd1);
    check("rstw_mem_valid", 32'(mem_valid), 32'd0);
    check("rstw_resp_valid", 32'(resp_valid), 32'd0);
    check("rstw_resp_err", 32'(resp_err), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    cpu_rs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstw_no_resp", 32'(resp_valid), 32'd0);
      check("rstw_no_bus", 32'(mem_valid), 32'd0);
    end
    mem_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
